// File: rtl/axis_byte_unpacker_if.sv
// AXI-stream bundles for the byte unpacker: a wide word stream with per-lane keep
// and a byte-wide stream with a last flag.
interface axis_word_if #(
  parameter int IEW = 2
);
  logic                    tvalid;
  logic                    tready;
  logic [(8 << IEW)-1:0]   tdata;
  logic [(1 << IEW)-1:0]   tkeep;

  modport master (output tvalid, tdata, tkeep, input tready);
  modport slave  (input tvalid, tdata, tkeep, output tready);
endinterface

interface axis_byte_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_byte_unpacker.sv
// Splits a (8<<IEW)-bit AXI-stream word into kept bytes, lowest lane first, flagging DELIM with tlast.
// Optional byte/block counters are enabled by defining AXIS_BYTE_UNPACKER_STATS_EN.
module axis_byte_unpacker #(
  parameter int         IEW   = 2,
  parameter logic [7:0] DELIM = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
`ifdef AXIS_BYTE_UNPACKER_STATS_EN
  output logic [31:0] o_byte_cnt,
  output logic [15:0] o_blk_cnt,
`endif
  axis_word_if.slave  i,
  axis_byte_if.master o
);
  localparam int LANES = 1 << IEW;
  localparam int W     = 8 * LANES;

  logic [W-1:0]     buf_data_reg;
  logic [LANES-1:0] buf_keep_reg;
  logic [7:0]       lane_byte [LANES];
  logic [LANES-1:0] pick_onehot;
  logic [7:0]       pick_byte;
  logic [LANES-1:0] rest_keep;
  logic             in_ready;
  logic             in_hs;
  logic             out_hs;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_byte[gi] = buf_data_reg[8*gi +: 8];
  end

  // Scan high to low so the lowest pending lane wins.
  always_comb begin
    pick_onehot = '0;
    pick_byte   = 8'h00;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (buf_keep_reg[k]) begin
        pick_onehot    = '0;
        pick_onehot[k] = 1'b1;
        pick_byte      = lane_byte[k];
      end
    end
  end

  assign rest_keep = buf_keep_reg & ~pick_onehot;
  // Accept a new word when empty, or when the last pending byte leaves this cycle.
  assign in_ready  = ~rst & (rest_keep == '0) & ((buf_keep_reg == '0) | o.tready);
  assign in_hs     = i.tvalid & in_ready;
  assign out_hs    = o.tvalid & o.tready;

  assign i.tready = in_ready;
  assign o.tvalid = |buf_keep_reg;
  assign o.tdata  = pick_byte;
  assign o.tlast  = o.tvalid & (pick_byte == DELIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data_reg <= '0;
      buf_keep_reg <= '0;
    end else if (in_hs) begin
      buf_data_reg <= i.tdata;
      buf_keep_reg <= i.tkeep;
    end else if (out_hs) begin
      buf_keep_reg <= rest_keep;
    end
  end

`ifdef AXIS_BYTE_UNPACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_byte_cnt <= '0;
      o_blk_cnt  <= '0;
    end else if (out_hs) begin
      o_byte_cnt <= o_byte_cnt + 32'd1;
      if (o.tlast) begin
        o_blk_cnt <= o_blk_cnt + 16'd1;
      end
    end
  end
`endif
endmodule
